// File: rtl/grostl_pkg.sv
// ----------------------------------------------------------------------------
// grostl_pkg
// Shared types and constants for the masked Grostl P/Q round sequencer.
//   grostl_state_t : 64-byte Grostl-256 state, byte index = 8*col + row
//   grostl_fsm_t   : sequencer states IDLE / ROUND / DONE
// ----------------------------------------------------------------------------
package grostl_pkg;

  localparam int GROSTL_ROWS       = 8;
  localparam int GROSTL_COLS       = 8;
  localparam int GROSTL_NUM_ROUNDS = 10;

  typedef logic [0:63][7:0] grostl_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } grostl_fsm_t;

endpackage

// File: rtl/grostl_round_const_m.sv
// ----------------------------------------------------------------------------
// grostl_round_const_m
// Combinational AddRoundConstant generator for Grostl-256 P and Q.
// Ports:
//   rnd   in  [RND_W-1:0]     current round number i
//   q_sel in  1               0 = P constants, 1 = Q constants
//   rc    out grostl_state_t  64-byte constant, byte index = 8*col + row
// P: row 0 = (col<<4) ^ i, other rows 0x00.
// Q: rows 0..6 = 0xFF, row 7 = 0xFF ^ (col<<4) ^ i.
// ----------------------------------------------------------------------------
module grostl_round_const_m
  import grostl_pkg::*;
#(
  parameter int RND_W = 4
) (
  input  logic [RND_W-1:0] rnd,
  input  logic             q_sel,
  output grostl_state_t    rc
);

  // Round number zero-extended into a byte.
  logic [7:0] rnd8;
  assign rnd8 = 8'(rnd);

  generate
    for (genvar gi = 0; gi < GROSTL_COLS; gi++) begin : g_col
      localparam logic [7:0] COL_HI = 8'(gi << 4);
      for (genvar gr = 0; gr < GROSTL_ROWS; gr++) begin : g_row
        if (gr == 0) begin : g_top
          assign rc[gi*GROSTL_ROWS + gr] = q_sel ? 8'hFF : (COL_HI ^ rnd8);
        end else if (gr == GROSTL_ROWS - 1) begin : g_bot
          assign rc[gi*GROSTL_ROWS + gr] = q_sel ? (8'hFF ^ COL_HI ^ rnd8) : 8'h00;
        end else begin : g_mid
          assign rc[gi*GROSTL_ROWS + gr] = q_sel ? 8'hFF : 8'h00;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/grostl_round_seq_m.sv
// ----------------------------------------------------------------------------
// grostl_round_seq_m
// Masked round sequencer for the 512-bit Grostl P/Q permutation. Holds the
// masked state and its mask, adds the round constant to the data share and
// hands it to an external masked SubBytes; the ShiftBytes/MixBytes result and
// its mask come back combinationally and are captured once per round.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, perm_q         begin request (IDLE only) and P/Q select
//   din, din_mask         masked input state and its mask
//   fresh_mask            PRNG bytes, used as SubBytes output mask when
//                         GROSTL_MASK_REFRESH_EN is defined
//   sb_din, sb_imask      masked state + constant and its mask, to SubBytes
//   sb_omask              output mask requested from SubBytes
//   rnd_din, rnd_mask     masked round result and its mask (feedback)
//   busy, done            busy in ROUND/DONE; done pulses for one cycle
//   dout, dout_mask       masked result and mask, held until overwritten
//
// Build option: GROSTL_MASK_REFRESH_EN
//   defined   : sb_omask = fresh_mask (new mask every round)
//   undefined : sb_omask = current mask, fresh_mask unused
// ----------------------------------------------------------------------------
module grostl_round_seq_m
  import grostl_pkg::*;
#(
  parameter int NUM_ROUNDS = GROSTL_NUM_ROUNDS,
  parameter int RND_W      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          perm_q,
  input  grostl_state_t din,
  input  grostl_state_t din_mask,
  input  grostl_state_t fresh_mask,
  output grostl_state_t sb_din,
  output grostl_state_t sb_imask,
  output grostl_state_t sb_omask,
  input  grostl_state_t rnd_din,
  input  grostl_state_t rnd_mask,
  output logic          busy,
  output logic          done,
  output grostl_state_t dout,
  output grostl_state_t dout_mask
);

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  grostl_fsm_t      fsm_reg;
  grostl_state_t    state_reg;
  grostl_state_t    mask_reg;
  logic [RND_W-1:0] rnd_reg;
  logic             q_sel_reg;
  logic             busy_reg;
  logic             done_reg;
  grostl_state_t    dout_reg;
  grostl_state_t    dout_mask_reg;

  grostl_state_t    rc;

  grostl_round_const_m #(
    .RND_W (RND_W)
  ) u_rc (
    .rnd   (rnd_reg),
    .q_sel (q_sel_reg),
    .rc    (rc)
  );

  // The constant only touches the data share; the mask passes unchanged,
  // so state ^ mask still carries the unmasked AddRoundConstant result.
  assign sb_din   = state_reg ^ rc;
  assign sb_imask = mask_reg;

`ifdef GROSTL_MASK_REFRESH_EN
  assign sb_omask = fresh_mask;
`else
  assign sb_omask = mask_reg;
  // fresh_mask is intentionally unused in this build.
  logic unused_fresh_mask;
  assign unused_fresh_mask = ^fresh_mask;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg       <= IDLE;
      state_reg     <= '0;
      mask_reg      <= '0;
      rnd_reg       <= '0;
      q_sel_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dout_reg      <= '0;
      dout_mask_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= din;
            mask_reg  <= din_mask;
            q_sel_reg <= perm_q;
            rnd_reg   <= '0;
            busy_reg  <= 1'b1;
            fsm_reg   <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= rnd_din;
          mask_reg  <= rnd_mask;
          rnd_reg   <= rnd_reg + 1'b1;
          if (rnd_reg == LAST_RND) begin
            // Capture the final round result directly so dout is valid in
            // the same cycle that done is high.
            dout_reg      <= rnd_din;
            dout_mask_reg <= rnd_mask;
            done_reg      <= 1'b1;
            fsm_reg       <= DONE;
          end
        end
        DONE: begin
          busy_reg <= 1'b0;
          fsm_reg  <= IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          fsm_reg  <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign dout      = dout_reg;
  assign dout_mask = dout_mask_reg;

endmodule

// File: tb/tb_grostl_round_seq_m.sv
// ----------------------------------------------------------------------------
// tb_grostl_round_seq_m
// Directed bench for grostl_round_seq_m. Plays the external masked SubBytes
// and ShiftBytes/MixBytes stages and carries an unmasked Grostl-256 reference
// permutation used as golden result.
// ----------------------------------------------------------------------------
module tb_grostl_round_seq_m;
  import grostl_pkg::*;

  localparam int NUM_R = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          perm_q;
  grostl_state_t din, din_mask, fresh_mask;
  grostl_state_t sb_din, sb_imask, sb_omask;
  grostl_state_t rnd_din, rnd_mask;
  logic          busy, done;
  grostl_state_t dout, dout_mask;
  logic          tb_q;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  grostl_round_seq_m dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .perm_q     (perm_q),
    .din        (din),
    .din_mask   (din_mask),
    .fresh_mask (fresh_mask),
    .sb_din     (sb_din),
    .sb_imask   (sb_imask),
    .sb_omask   (sb_omask),
    .rnd_din    (rnd_din),
    .rnd_mask   (rnd_mask),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .dout_mask  (dout_mask)
  );

  // ---------------- Grostl reference arithmetic ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // AES S-box: inverse in GF(2^8) (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] s;
    r = 8'h01; base = a;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    s = r;
    for (int k = 0; k < 4; k++) begin
      s = {s[6:0], s[7]};
      r = r ^ s;
    end
    return r ^ 8'h63;
  endfunction

  function automatic grostl_state_t rc_ref(input int i, input logic q);
    grostl_state_t c;
    for (int j = 0; j < 8; j++)
      for (int r = 0; r < 8; r++) begin
        if (q) c[8*j+r] = (r == 7) ? (8'hFF ^ 8'(j << 4) ^ 8'(i)) : 8'hFF;
        else   c[8*j+r] = (r == 0) ? (8'(j << 4) ^ 8'(i)) : 8'h00;
      end
    return c;
  endfunction

  function automatic grostl_state_t shift_bytes(input grostl_state_t s, input logic q);
    grostl_state_t o;
    int sh;
    for (int r = 0; r < 8; r++) begin
      sh = q ? ((r < 4) ? (2*r + 1) : (2*r - 8)) : r;
      for (int j = 0; j < 8; j++) o[8*j+r] = s[8*((j + sh) % 8) + r];
    end
    return o;
  endfunction

  function automatic logic [7:0] mix_coef(input int k);
    case (k)
      0, 1:    return 8'h02;
      2, 5:    return 8'h03;
      3:       return 8'h04;
      4, 6:    return 8'h05;
      default: return 8'h07;
    endcase
  endfunction

  function automatic grostl_state_t mix_bytes(input grostl_state_t s);
    grostl_state_t o;
    logic [7:0] acc;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++) begin
        acc = 8'h00;
        for (int k = 0; k < 8; k++) acc = acc ^ gf_mul(mix_coef(k), s[8*j + (i+k)%8]);
        o[8*j+i] = acc;
      end
    return o;
  endfunction

  function automatic grostl_state_t sub_masked(input grostl_state_t d, input grostl_state_t im,
                                               input grostl_state_t om);
    grostl_state_t o;
    for (int b = 0; b < 64; b++) o[b] = sbox(d[b] ^ im[b]) ^ om[b];
    return o;
  endfunction

  function automatic grostl_state_t perm_ref(input grostl_state_t u, input logic q);
    grostl_state_t s;
    s = u;
    for (int i = 0; i < NUM_R; i++)
      s = mix_bytes(shift_bytes(sub_masked(s ^ rc_ref(i, q), '0, '0), q));
    return s;
  endfunction

  // External masked datapath: SubBytes then the linear layers on both shares.
  always_comb begin
    rnd_din  = '0;
    rnd_mask = '0;
    rnd_din  = mix_bytes(shift_bytes(sub_masked(sb_din, sb_imask, sb_omask), tb_q));
    rnd_mask = mix_bytes(shift_bytes(sb_omask, tb_q));
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete permutation with per-cycle checks; optional start pulses
  // during cycles 4 and 11 must be ignored.
  task automatic run_perm(input grostl_state_t d, input grostl_state_t m, input logic q,
                          input logic inject, output grostl_state_t res);
    grostl_state_t prev_d, prev_m, exp_res;
    exp_res = perm_ref(d ^ m, q);
    @(negedge clk);
    din = d; din_mask = m; perm_q = q; tb_q = q; start = 1'b1;
    prev_d = d; prev_m = m;
    @(posedge clk); #1;
    start = 1'b0; perm_q = ~q; din = ~d;
    for (int c = 1; c <= NUM_R + 2; c++) begin
      start = inject && (c == 4 || c == 11);
      fresh_mask = (c == 1) ? {64{8'hA5}} : {16{$urandom()}};
      @(negedge clk);
      if (c <= NUM_R) begin
        check("busy_done_round", {busy, done}, 2'b10);
        check("sb_din", sb_din, prev_d ^ rc_ref(c - 1, q));
        check("sb_imask", sb_imask, prev_m);
`ifdef GROSTL_MASK_REFRESH_EN
        check("sb_omask_fresh", sb_omask, fresh_mask);
`else
        check("sb_omask_eq_imask", sb_omask, sb_imask);
`endif
        if (c == 4) begin
          if (q) begin
            check("rc3_q_b15", sb_din[15], prev_d[15] ^ 8'hEC);
            check("rc3_q_b8", sb_din[8], prev_d[8] ^ 8'hFF);
          end else begin
            check("rc3_p_b8", sb_din[8], prev_d[8] ^ 8'h13);
            check("rc3_p_b9", sb_din[9], prev_d[9]);
          end
        end
        prev_d = rnd_din; prev_m = rnd_mask;
      end else if (c == NUM_R + 1) begin
        check("busy_done_pulse", {busy, done}, 2'b11);
        check("dout_unmasked", dout ^ dout_mask, exp_res);
      end else begin
        check("busy_done_idle", {busy, done}, 2'b00);
        check("dout_hold", dout ^ dout_mask, exp_res);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    res = dout ^ dout_mask;
  endtask

  grostl_state_t r0, r1, r2, r3, dq, mq1, mq2, dp, mp;

  initial begin
    rst_n = 1'b0; start = 1'b0; perm_q = 1'b0; tb_q = 1'b0;
    din = '0; din_mask = '0; fresh_mask = '0;
    for (int b = 0; b < 64; b++) begin
      dq[b] = 8'($urandom()); mq1[b] = 8'($urandom()); mq2[b] = 8'($urandom());
      dp[b] = 8'($urandom()); mp[b] = 8'($urandom());
    end

    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, '0);
    check("rst_dout_mask", dout_mask, '0);
    check("rst_sb_din_b8", sb_din[8], 8'h10);
    check("rst_sb_din_b9", sb_din[9], 8'h00);
    #9 rst_n = 1'b1;

    // P(0) with all-zero data and mask.
    run_perm('0, '0, 1'b0, 1'b0, r0);
    $display("txn P zero     unmasked=%h", r0);

    // Q with random data/mask, spurious starts while busy.
    run_perm(dq, mq1, 1'b1, 1'b1, r1);
    $display("txn Q mask1    unmasked=%h", r1);

    // Same unmasked input under a different mask.
    run_perm(dq ^ mq1 ^ mq2, mq2, 1'b1, 1'b0, r2);
    check("q_mask_independent", r2, r1);
    $display("txn Q mask2    unmasked=%h", r2);

    // Reset in cycle 5 of a P run.
    @(negedge clk);
    din = dp; din_mask = mp; perm_q = 1'b0; tb_q = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_dout", dout, '0);
    check("midrst_dout_mask", dout_mask, '0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold", {busy, done}, 2'b00);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("postrst_idle", {busy, done}, 2'b00);
    end
    $display("txn reset mid-run busy=%0b done=%0b", busy, done);

    run_perm(dp, mp, 1'b0, 1'b0, r3);
    $display("txn P after rst unmasked=%h", r3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
